mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sequencer and arbiter for the single byte-wide external memory port, shared by two requesters: instruction fetch (4-byte read) and load/store (1/2/4-byte read or write).
Serialises each request into per-byte bus cycles, assembles and splits little-endian words, and returns a one-cycle done pulse per request.
Sits between the IF/LS front ends and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
ADDR_W, 32, address width of requests and mem_a
IO_MASK_BIT, 17, upper bit of the 2-bit I/O region select; mem_a[17:16]==2'b11 is I/O

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global ready; low freezes the block
if_req  in  1  fetch request, level, held until if_done
if_addr  in  32  fetch address; byte-aligned word read
if_flush  in  1  abort any fetch in progress (branch redirect)
if_data  out  32  fetched word, valid while if_done=1
if_done  out  1  one-cycle completion pulse
ls_req  in  1  load/store request, level, held until ls_done
ls_wr  in  1  1=store, 0=load
ls_addr  in  32  byte address
ls_size  in  2  00=byte, 01=half, 10=word; 11 is illegal and treated as word
ls_wdata  in  32  store data; byte i at ls_addr+i is bits [8i+7:8i]
ls_rdata  out  32  load data, zero-extended raw bytes, valid while ls_done=1
ls_done  out  1  one-cycle completion pulse
mem_din  in  8  memory read data
mem_dout  out  8  memory write data
mem_a  out  32  memory address
mem_wr  out  1  1=write

Behaviour:
- Reset (rst=1 at edge, dominates rdy): state IDLE; mem_a, mem_dout, if_data, ls_rdata = 0; mem_wr, if_done, ls_done = 0; rr_last = LS. A transaction in flight is discarded with no done pulse.
- rdy=0: all registers hold. mem_wr output is gated to 0 combinationally. On resume the held byte cycle re-drives, so each store byte is written exactly once.
- States: IDLE, READ, WRITE.
- Arbitration happens in IDLE only.
  - A port whose done is high this cycle is masked from acceptance.
  - If both ports request, the port not served last wins (rr_last). If only one requests, it wins.
  - if_req is not accepted in a cycle where if_flush=1.
- Acceptance edge E0: latch op, address and byte count N (IF: 4, LS: 1/2/4); set mem_a <= addr.
  - Store: also mem_wr <= 1, mem_dout <= byte0; go to WRITE.
  - Load/fetch: mem_wr <= 0; go to READ.
- READ, pipelined:
  - At edge Ek (k=1..N-1), mem_a <= addr+k.
  - At edge E(k+1), mem_din is captured into byte lane k.
  - At edge E(N+1): done and the assembled data register are set; state goes to IDLE.
  - A word read therefore shows done in the cycle after E5. Unused upper lanes are 0.
- WRITE:
  - At edge Ek (k=1..N-1), mem_a <= addr+k and mem_dout <= byte k.
  - At edge EN: mem_wr <= 0, mem_a <= 0, ls_done <= 1, state goes to IDLE.
- Address arithmetic is ADDR_W-bit modulo; no alignment check.
- Done pulses last exactly one cycle (cleared at the next un-stalled edge). Data outputs hold their value until the next completion of the same port.
- if_flush while an IF transaction is active: return to IDLE at the next edge, mem_a <= 0, no if_done. if_flush has no effect on an LS transaction or when idle.
- I/O: addresses with mem_a[17:16]==2'b11 are accessed only on behalf of the LS port, never speculatively. IF requests to the I/O region are still performed (this is a software error and is not checked).
- mem_wr is never 1 during READ or IDLE.

Decomposition:
- Shared defines header (existing):
  - addr_t, word_t, byte_t widths
  - new LS size codes LS_BYTE, LS_HALF, LS_WORD
  - new state encodings MA_IDLE, MA_READ, MA_WRITE
- Single module; no sub-module. The byte-lane insert/extract logic is a case statement inside it.

Test Plan:
- IF word read @0x00000010, memory bytes 0x13,0x05,0x00,0x00 -> mem_a 0x10,0x11,0x12,0x13 on consecutive cycles, mem_wr=0 throughout, if_data=0x00000513, if_done one pulse in the cycle after E5.
- LS half store 0x00001234 @0x100 -> cycle1: mem_a=0x100, dout=0x34, wr=1; cycle2: mem_a=0x101, dout=0x12, wr=1; cycle3: wr=0, ls_done=1.
- if_req and ls_req asserted together in IDLE, rr_last=LS -> IF served first, then LS; re-assert both -> IF served first again.
- if_flush at E2 of an IF read with ls_req pending -> no if_done; LS accepted at the first IDLE edge; memory shows no extra writes.
- LS word store 0x44434241 @0x30000 with rdy low for 3 cycles after byte 1 -> mem_wr=0 during the stall; exactly 4 write cycles carrying 0x41,0x42,0x43,0x44 in order; single ls_done.
- rst=1 during byte 2 of an LS word read -> at the next edge all outputs are 0 and state is IDLE, no ls_done; a new if_req afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the external memory
// port sequencer and its two requesters.
package mem_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10
  } ls_size_e;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'b00,
    MA_READ  = 2'b01,
    MA_WRITE = 2'b10
  } ma_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  localparam logic [2:0] IF_BYTES = 3'd4;

  function automatic logic [2:0] ls_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    case (sz)
      LS_BYTE: n = 3'd1;
      LS_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic byte_t get_lane(
    input word_t      w,
    input logic [1:0] i
  );
    byte_t b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic word_t put_lane(
    input word_t      w,
    input logic [1:0] i,
    input byte_t      b
  );
    word_t r;
    r = w;
    case (i)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial sequencer and round-robin arbiter between
// instruction fetch and load/store on the memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int IO_MASK_BIT = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_size,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  ma_state_e         state_q, state_d;
  port_e             port_q, port_d;
  port_e             rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        k_q, k_d;
  word_t             wbuf_q, wbuf_d;
  word_t             rbuf_q, rbuf_d;
  word_t             if_data_q, if_data_d;
  word_t             ls_rdata_q, ls_rdata_d;
  byte_t             dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;

  logic              if_ok, ls_ok;
  logic              take_if, take_ls;
  logic [1:0]        rd_lane;
  logic [ADDR_W-1:0] next_a;
  logic              last_io;

  assign if_ok   = if_req & ~if_done_q & ~if_flush;
  assign ls_ok   = ls_req & ~ls_done_q;
  assign take_if = if_ok & (~ls_ok | (rr_last_q == PORT_LS));
  assign take_ls = ls_ok & ~take_if;
  assign rd_lane = k_q[1:0] - 2'd1;
  assign next_a  = base_q + ADDR_W'(k_q);
  assign last_io = &mem_a_q[IO_MASK_BIT -: 2];

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    rr_last_d  = rr_last_q;
    base_d     = base_q;
    mem_a_d    = mem_a_q;
    n_d        = n_q;
    k_d        = k_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    unique case (state_q)
      MA_IDLE: begin
        unique case (1'b1)
          take_if: begin
            port_d    = PORT_IF;
            rr_last_d = PORT_IF;
            base_d    = if_addr;
            mem_a_d   = if_addr;
            n_d       = IF_BYTES;
            k_d       = 3'd1;
            rbuf_d    = '0;
            wr_d      = 1'b0;
            state_d   = MA_READ;
          end
          take_ls: begin
            port_d    = PORT_LS;
            rr_last_d = PORT_LS;
            base_d    = ls_addr;
            mem_a_d   = ls_addr;
            n_d       = ls_bytes(ls_size);
            k_d       = 3'd1;
            rbuf_d    = '0;
            wbuf_d    = ls_wdata;
            if (ls_wr) begin
              wr_d    = 1'b1;
              dout_d  = ls_wdata[7:0];
              state_d = MA_WRITE;
            end else begin
              wr_d    = 1'b0;
              state_d = MA_READ;
            end
          end
          default: ;
        endcase
      end
      MA_READ: begin
        if (port_q == PORT_IF && if_flush) begin
          mem_a_d = '0;
          state_d = MA_IDLE;
        end else if (k_q > n_q) begin
          mem_a_d = '0;
          state_d = MA_IDLE;
          if (port_q == PORT_IF) begin
            if_data_d = rbuf_q;
            if_done_d = 1'b1;
          end else begin
            ls_rdata_d = rbuf_q;
            ls_done_d  = 1'b1;
          end
        end else begin
          rbuf_d = put_lane(rbuf_q, rd_lane, mem_din);
          k_d    = k_q + 3'd1;
          if (k_q < n_q) begin
            mem_a_d = next_a;
          end else if (last_io) begin
            // park early so an I/O device is not re-addressed
            mem_a_d = '0;
          end
        end
      end
      MA_WRITE: begin
        if (k_q < n_q) begin
          mem_a_d = next_a;
          dout_d  = get_lane(wbuf_q, k_q[1:0]);
          k_d     = k_q + 3'd1;
        end else begin
          wr_d      = 1'b0;
          mem_a_d   = '0;
          ls_done_d = 1'b1;
          state_d   = MA_IDLE;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MA_IDLE;
      port_q     <= PORT_IF;
      rr_last_q  <= PORT_LS;
      base_q     <= '0;
      mem_a_q    <= '0;
      n_q        <= '0;
      k_q        <= '0;
      wbuf_q     <= '0;
      rbuf_q     <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      port_q     <= port_d;
      rr_last_q  <= rr_last_d;
      base_q     <= base_d;
      mem_a_q    <= mem_a_d;
      n_q        <= n_d;
      k_q        <= k_d;
      wbuf_q     <= wbuf_d;
      rbuf_q     <= rbuf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = dout_q;
  assign mem_wr   = wr_q & rdy;
  assign if_data  = if_data_q;
  assign if_done  = if_done_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_done  = ls_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural
// byte-wide memory and a write log.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_data;
  logic        if_done;
  logic        ls_req;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_chk;
  int n_err;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];

  mem_arbiter #(
    .ADDR_W(32),
    .IO_MASK_BIT(17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_flush(if_flush),
    .if_data(if_data),
    .if_done(if_done),
    .ls_req(ls_req),
    .ls_wr(ls_wr),
    .ls_addr(ls_addr),
    .ls_size(ls_size),
    .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata),
    .ls_done(ls_done),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_a(mem_a),
    .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_a] = mem_dout;
      wa_q.push_back(mem_a);
      wd_q.push_back(mem_dout);
    end
  end

  always @(negedge clk) begin
    mem_din = mem.exists(mem_a) ? mem[mem_a] : 8'h00;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_if(output int cyc);
    cyc = 0;
    while (!if_done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_ls(output int cyc);
    cyc = 0;
    while (!ls_done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;
  int nw;

  initial begin
    n_chk    = 0;
    n_err    = 0;
    mem_din  = 8'h00;
    rst      = 1'b1;
    rdy      = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    ls_req   = 1'b0;
    ls_wr    = 1'b0;
    ls_addr  = '0;
    ls_size  = 2'b00;
    ls_wdata = '0;
    mem[32'h10] = 8'h13;
    mem[32'h11] = 8'h05;
    mem[32'h12] = 8'h00;
    mem[32'h13] = 8'h00;
    tick();
    tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst_dout", {24'b0, mem_dout}, 32'h0);
    chk("rst_if_done", {31'b0, if_done}, 32'h0);
    chk("rst_ls_done", {31'b0, ls_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // IF word read
    if_req  = 1'b1;
    if_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("if_rd_a", mem_a, 32'h10 + 32'(k));
      chk("if_rd_wr", {31'b0, mem_wr}, 32'h0);
      chk("if_rd_done", {31'b0, if_done}, 32'h0);
    end
    tick();
    chk("if_rd_done_e4", {31'b0, if_done}, 32'h0);
    tick();
    chk("if_rd_done_e5", {31'b0, if_done}, 32'h1);
    chk("if_rd_data", if_data, 32'h00000513);
    if_req = 1'b0;
    tick();
    chk("if_rd_pulse", {31'b0, if_done}, 32'h0);
    chk("if_rd_hold", if_data, 32'h00000513);

    // LS half store
    ls_req   = 1'b1;
    ls_wr    = 1'b1;
    ls_addr  = 32'h100;
    ls_size  = 2'b01;
    ls_wdata = 32'h00001234;
    tick();
    chk("hs_a0", mem_a, 32'h100);
    chk("hs_d0", {24'b0, mem_dout}, 32'h34);
    chk("hs_w0", {31'b0, mem_wr}, 32'h1);
    tick();
    chk("hs_a1", mem_a, 32'h101);
    chk("hs_d1", {24'b0, mem_dout}, 32'h12);
    chk("hs_w1", {31'b0, mem_wr}, 32'h1);
    tick();
    chk("hs_w2", {31'b0, mem_wr}, 32'h0);
    chk("hs_done", {31'b0, ls_done}, 32'h1);
    ls_req = 1'b0;
    tick();
    chk("hs_pulse", {31'b0, ls_done}, 32'h0);
    chk("hs_mem", {mem[32'h101], mem[32'h100]}, 32'h1234);

    // round robin: both request, last was LS
    for (int r = 0; r < 2; r++) begin
      if_req  = 1'b1;
      if_addr = 32'h10;
      ls_req  = 1'b1;
      ls_wr   = 1'b0;
      ls_addr = 32'h100;
      ls_size = 2'b00;
      tick();
      chk("rr_if_first", mem_a, 32'h10);
      wait_if(cyc);
      chk("rr_if_lat", cyc, 5);
      chk("rr_if_data", if_data, 32'h00000513);
      if_req = 1'b0;
      tick();
      chk("rr_ls_next", mem_a, 32'h100);
      wait_ls(cyc);
      chk("rr_ls_lat", cyc, 2);
      chk("rr_ls_data", ls_rdata, 32'h00000034);
      ls_req = 1'b0;
      tick();
    end

    // flush an IF read with a store pending
    nw      = wa_q.size();
    if_req  = 1'b1;
    if_addr = 32'h10;
    tick();
    ls_req   = 1'b1;
    ls_wr    = 1'b1;
    ls_addr  = 32'h204;
    ls_size  = 2'b00;
    ls_wdata = 32'h0000005A;
    tick();
    if_flush = 1'b1;
    tick();
    chk("fl_a", mem_a, 32'h0);
    chk("fl_done", {31'b0, if_done}, 32'h0);
    if_flush = 1'b0;
    if_req   = 1'b0;
    tick();
    chk("fl_ls_a", mem_a, 32'h204);
    chk("fl_ls_d", {24'b0, mem_dout}, 32'h5A);
    chk("fl_ls_w", {31'b0, mem_wr}, 32'h1);
    tick();
    chk("fl_ls_done", {31'b0, ls_done}, 32'h1);
    chk("fl_if_done", {31'b0, if_done}, 32'h0);
    ls_req = 1'b0;
    tick();
    chk("fl_nwrites", wa_q.size() - nw, 1);

    // word store to I/O with a stall after byte 1
    nw       = wa_q.size();
    ls_req   = 1'b1;
    ls_wr    = 1'b1;
    ls_addr  = 32'h30000;
    ls_size  = 2'b10;
    ls_wdata = 32'h44434241;
    tick();
    chk("st_a0", mem_a, 32'h30000);
    chk("st_d0", {24'b0, mem_dout}, 32'h41);
    tick();
    chk("st_a1", mem_a, 32'h30001);
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("st_stall_wr", {31'b0, mem_wr}, 32'h0);
      chk("st_stall_a", mem_a, 32'h30001);
      chk("st_stall_done", {31'b0, ls_done}, 32'h0);
    end
    rdy = 1'b1;
    tick();
    chk("st_a2", mem_a, 32'h30002);
    chk("st_d2", {24'b0, mem_dout}, 32'h43);
    tick();
    chk("st_a3", mem_a, 32'h30003);
    chk("st_d3", {24'b0, mem_dout}, 32'h44);
    tick();
    chk("st_done", {31'b0, ls_done}, 32'h1);
    chk("st_wr_end", {31'b0, mem_wr}, 32'h0);
    chk("st_a_end", mem_a, 32'h0);
    ls_req = 1'b0;
    tick();
    chk("st_pulse", {31'b0, ls_done}, 32'h0);
    chk("st_nwrites", wa_q.size() - nw, 4);
    for (int w = 0; w < 4; w++) begin
      if (nw + w < wa_q.size()) begin
        chk("st_log_a", wa_q[nw + w], 32'h30000 + 32'(w));
        chk("st_log_d", {24'b0, wd_q[nw + w]}, 32'h41 + 32'(w));
      end
    end

    // reset during byte 2 of an LS word read
    ls_req  = 1'b1;
    ls_wr   = 1'b0;
    ls_addr = 32'h10;
    ls_size = 2'b10;
    tick();
    tick();
    tick();
    chk("rr_byte2", mem_a, 32'h12);
    rst = 1'b1;
    tick();
    chk("mr_a", mem_a, 32'h0);
    chk("mr_dout", {24'b0, mem_dout}, 32'h0);
    chk("mr_ls_done", {31'b0, ls_done}, 32'h0);
    chk("mr_ls_rdata", ls_rdata, 32'h0);
    chk("mr_if_data", if_data, 32'h0);
    rst    = 1'b0;
    ls_req = 1'b0;
    tick();
    chk("mr_idle_done", {31'b0, ls_done}, 32'h0);
    if_req  = 1'b1;
    if_addr = 32'h10;
    tick();
    chk("mr_if_a", mem_a, 32'h10);
    wait_if(cyc);
    chk("mr_if_lat", cyc, 5);
    chk("mr_if_data", if_data, 32'h00000513);
    if_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
